sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
// - Two-requester arbiter/sequencer sharing the single SRAM controller port (e.g. req0 = data cache miss/fill, req1 = write-back/store path).
// - Latches the winning request's attributes, drives one SRAM transaction at a time, and returns the completion ready and the 64-bit read data to the winning requester only.
// - Sits between the cache/MEM stage and the SRAM controller, in the same clock domain.
// PARAMETERS
// - ADDR_W   32  request/SRAM byte-address width
// - WDATA_W  32  write data width
// - RDATA_W  64  read data width (SRAM controller line width)
// PORTS
// - clk              in   1        system clock, all logic on rising edge
// - rst              in   1        synchronous, active-high reset
// - reqN_read_en     in   1        N=0,1: read request, held until reqN_ready=1
// - reqN_write_en    in   1        N=0,1: write request, held until reqN_ready=1
// - reqN_address     in   ADDR_W   N=0,1: byte address
// - reqN_write_data  in   WDATA_W  N=0,1: write data
// - reqN_read_data   out  RDATA_W  N=0,1: read data, valid in completion cycle, then held
// - reqN_ready       out  1        N=0,1: 1 = idle or transaction complete this cycle
// - mem_read_en      out  1        to SRAM controller read_en
// - mem_write_en     out  1        to SRAM controller write_en
// - mem_address      out  ADDR_W   to SRAM controller address
// - mem_write_data   out  WDATA_W  to SRAM controller writeData
// - mem_read_data    in   RDATA_W  from SRAM controller readData
// - mem_ready        in   1        from SRAM controller ready
// - grant            out  2        one-hot current owner {req1,req0}, 00 in IDLE
// - busy             out  1        1 while in a GRANT state
// BEHAVIOUR
// - FSM states: IDLE, GRANT0, GRANT1. Reset (sync rst=1) -> IDLE.
// - Reset values: mem_* enables 0, mem_address/mem_write_data 0, grant 00, busy 0, reqN_read_data 0, last_grant = 1 (req0 wins first tie).
// - Request pending for N: reqN_pend = reqN_read_en | reqN_write_en. If both enables are 1, read wins; the write is ignored.
// - IDLE: mem enables 0; mem_ready ignored. If any pend: pick winner, latch its rd/wr type, address, and write data; go to GRANTx next edge.
// - Arbitration: round-robin. Single pending requester wins. When both are pending, the requester != last_grant wins. last_grant updates on entry to GRANT.
// - GRANTx: mem_* driven only from the latched registers, never directly from requester inputs. mem_read_en/mem_write_en held constant for the whole state.
// - Completion: in GRANTx, when mem_ready=1 -> reqx_ready=1 for exactly that cycle; reqx_read_data captures mem_read_data (combinational pass-through that cycle, registered hold after); next state IDLE.
// - Latency: request seen in IDLE at cycle N -> mem enable high at N+1. Minimum one IDLE cycle between back-to-back transactions (mem enables low for >=1 cycle).
// - reqN_ready: 1 when reqN_pend=0; 0 while pending and not completing. The losing requester stays 0 through the other's whole transaction.
// - Requester withdraws or changes inputs mid-grant: the transaction continues from latched values. The completion pulse is still generated and the requester must tolerate it.
// - Write-only transaction: reqN_read_data is not updated.
// - Reset mid-transaction: next edge IDLE, enables drop, no ready pulse. The SRAM controller shares rst, so its state is also cleared.
// - No timeout: a GRANT state waits on mem_ready indefinitely.
// CONFIGURATION
// - ARB_FIXED_PRIORITY_EN defined: fixed priority; req0 always wins a tie; last_grant is unused (may be removed).
// - ARB_FIXED_PRIORITY_EN undefined (default): round-robin as above.
// TESTING
// - Single read: req0_read_en=1, addr 0x0000_0100, mem_ready pulses 6 cycles after grant, mem_read_data=0xDEAD_BEEF_0123_4567 -> mem_read_en=1 with mem_address 0x100 one cycle after request; req0_ready=1 exactly in the mem_ready cycle; req0_read_data holds 0xDEADBEEF01234567 afterward.
// - Simultaneous: req0 write 0x200/0x11111111 and req1 read 0x300 both in the same cycle after reset -> req0 served first, >=1 IDLE cycle, then req1. Repeat the tie: req1 first (round-robin); with ARB_FIXED_PRIORITY_EN, req0 first.
// - Losing requester: req1 pending during req0's transaction -> req1_ready=0 throughout; grant=01 then 00 then 10.
// - Withdrawal: req0 drops read_en and changes address to 0x999 two cycles into GRANT0 -> mem_address stays at the original value; mem_read_en stays high until mem_ready; one-cycle req0_ready pulse.
// - Reset mid-grant: rst=1 for one cycle during GRANT1 -> next cycle grant=00, busy=0, mem enables 0, no req1_ready pulse; a new request afterward is served normally.
// - Read+write same requester: req1_read_en=req1_write_en=1 -> mem_read_en=1, mem_write_en=0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester, SRAM-controller and status signals of the two-port SRAM arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64
);
    logic               req0_read_en;
    logic               req0_write_en;
    logic [ADDR_W-1:0]  req0_address;
    logic [WDATA_W-1:0] req0_write_data;
    logic [RDATA_W-1:0] req0_read_data;
    logic               req0_ready;
    logic               req1_read_en;
    logic               req1_write_en;
    logic [ADDR_W-1:0]  req1_address;
    logic [WDATA_W-1:0] req1_write_data;
    logic [RDATA_W-1:0] req1_read_data;
    logic               req1_ready;
    logic               mem_read_en;
    logic               mem_write_en;
    logic [ADDR_W-1:0]  mem_address;
    logic [WDATA_W-1:0] mem_write_data;
    logic [RDATA_W-1:0] mem_read_data;
    logic               mem_ready;
    logic [1:0]         grant;
    logic               busy;

    modport slave (
        input  req0_read_en, req0_write_en, req0_address, req0_write_data,
        input  req1_read_en, req1_write_en, req1_address, req1_write_data,
        input  mem_read_data, mem_ready,
        output req0_read_data, req0_ready, req1_read_data, req1_ready,
        output mem_read_en, mem_write_en, mem_address, mem_write_data,
        output grant, busy
    );

    modport master (
        output req0_read_en, req0_write_en, req0_address, req0_write_data,
        output req1_read_en, req1_write_en, req1_address, req1_write_data,
        output mem_read_data, mem_ready,
        input  req0_read_data, req0_ready, req1_read_data, req1_ready,
        input  mem_read_en, mem_write_en, mem_address, mem_write_data,
        input  grant, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single SRAM controller port, one transaction at a time.
// ARB_FIXED_PRIORITY_EN: when defined, req0 always wins a tie; otherwise round-robin.
module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               pend0_s;
    logic               pend1_s;
    logic               win1_s;
    logic               start_s;
    logic               done0_s;
    logic               done1_s;
    logic               mem_read_en_r;
    logic               mem_write_en_r;
    logic [ADDR_W-1:0]  mem_address_r;
    logic [WDATA_W-1:0] mem_write_data_r;
    logic [RDATA_W-1:0] rd_hold0_r;
    logic [RDATA_W-1:0] rd_hold1_r;
`ifndef ARB_FIXED_PRIORITY_EN
    logic               last_grant_r;
`endif

    // Arbitration, completion detection and next-state selection
    always_comb begin
        pend0_s = bus.req0_read_en | bus.req0_write_en;
        pend1_s = bus.req1_read_en | bus.req1_write_en;
`ifdef ARB_FIXED_PRIORITY_EN
        win1_s  = pend1_s & ~pend0_s;
`else
        // last_grant_r = 1 means req1 was served last, so req0 takes the tie
        win1_s  = pend1_s & (~pend0_s | ~last_grant_r);
`endif
        done0_s = (state_r == GRANT0) & bus.mem_ready & ~rst;
        done1_s = (state_r == GRANT1) & bus.mem_ready & ~rst;
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pend0_s | pend1_s) begin
                    state_s = win1_s ? GRANT1 : GRANT0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT0: begin
                if (done0_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GRANT0;
                end
            end
            GRANT1: begin
                if (done1_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GRANT1;
                end
            end
            default: state_s = IDLE;
        endcase
        start_s = (state_r == IDLE) & (state_s != IDLE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the winner's transaction; enables stay constant until completion
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_en_r    <= 1'b0;
            mem_write_en_r   <= 1'b0;
            mem_address_r    <= {ADDR_W{1'b0}};
            mem_write_data_r <= {WDATA_W{1'b0}};
        end else if (start_s) begin
            if (win1_s) begin
                mem_read_en_r    <= bus.req1_read_en;
                mem_write_en_r   <= bus.req1_write_en & ~bus.req1_read_en;
                mem_address_r    <= bus.req1_address;
                mem_write_data_r <= bus.req1_write_data;
            end else begin
                mem_read_en_r    <= bus.req0_read_en;
                mem_write_en_r   <= bus.req0_write_en & ~bus.req0_read_en;
                mem_address_r    <= bus.req0_address;
                mem_write_data_r <= bus.req0_write_data;
            end
        end else if (done0_s | done1_s) begin
            mem_read_en_r  <= 1'b0;
            mem_write_en_r <= 1'b0;
        end
    end

`ifndef ARB_FIXED_PRIORITY_EN
    // Remember who was granted last for round-robin tie breaking
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (start_s) begin
            last_grant_r <= win1_s;
        end
    end
`endif

    // Hold read data after a read completes; write-only completions leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hold0_r <= {RDATA_W{1'b0}};
            rd_hold1_r <= {RDATA_W{1'b0}};
        end else begin
            if (done0_s & mem_read_en_r) begin
                rd_hold0_r <= bus.mem_read_data;
            end
            if (done1_s & mem_read_en_r) begin
                rd_hold1_r <= bus.mem_read_data;
            end
        end
    end

    assign bus.mem_read_en    = mem_read_en_r;
    assign bus.mem_write_en   = mem_write_en_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.grant          = {state_r == GRANT1, state_r == GRANT0};
    assign bus.busy           = (state_r != IDLE);
    // The owner sees ready only in its completion cycle; others see ready while not pending
    assign bus.req0_ready     = (state_r == GRANT0) ? done0_s : ~pend0_s;
    assign bus.req1_ready     = (state_r == GRANT1) ? done1_s : ~pend1_s;
    assign bus.req0_read_data = (done0_s & mem_read_en_r) ? bus.mem_read_data : rd_hold0_r;
    assign bus.req1_read_data = (done1_s & mem_read_en_r) ? bus.mem_read_data : rd_hold1_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter: reads, writes, ties, withdrawal and reset mid-grant.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   first_win;

    sram_arbiter_if #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(64)) bus ();

    sram_arbiter #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive mem_ready for one cycle, check the owner's completion, then drop its request.
    task automatic finish_txn(input int who, input logic [63:0] d, input logic [63:0] exp_rd);
        bus.mem_read_data = d;
        bus.mem_ready = 1'b1;
        #1;
        chk("done_ready", 64'(who == 1 ? bus.req1_ready : bus.req0_ready), 64'h1);
        chk("done_rdata", who == 1 ? bus.req1_read_data : bus.req0_read_data, exp_rd);
        step();
        bus.mem_ready = 1'b0;
        bus.mem_read_data = 64'h0;
        if (who == 1) begin
            bus.req1_read_en = 1'b0;
            bus.req1_write_en = 1'b0;
        end else begin
            bus.req0_read_en = 1'b0;
            bus.req0_write_en = 1'b0;
        end
        #1;
        chk("after_grant", 64'(bus.grant), 64'h0);
        chk("after_rd_en", 64'(bus.mem_read_en), 64'h0);
        chk("after_rdata_hold", who == 1 ? bus.req1_read_data : bus.req0_read_data, exp_rd);
    endtask

    initial begin
        bus.req0_read_en = 1'b0;  bus.req0_write_en = 1'b0;
        bus.req0_address = 32'h0; bus.req0_write_data = 32'h0;
        bus.req1_read_en = 1'b0;  bus.req1_write_en = 1'b0;
        bus.req1_address = 32'h0; bus.req1_write_data = 32'h0;
        bus.mem_read_data = 64'h0; bus.mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_rd_en", 64'(bus.mem_read_en), 64'h0);
        chk("rst_wr_en", 64'(bus.mem_write_en), 64'h0);
        chk("rst_addr", 64'(bus.mem_address), 64'h0);
        chk("rst_wdata", 64'(bus.mem_write_data), 64'h0);
        chk("rst_rdata0", bus.req0_read_data, 64'h0);
        chk("rst_rdata1", bus.req1_read_data, 64'h0);
        chk("rst_ready0", 64'(bus.req0_ready), 64'h1);

        // Single read from req0, completion six cycles after grant
        bus.req0_read_en = 1'b1;
        bus.req0_address = 32'h0000_0100;
        #1;
        chk("t1_pend_ready", 64'(bus.req0_ready), 64'h0);
        step();
        chk("t1_rd_en", 64'(bus.mem_read_en), 64'h1);
        chk("t1_addr", 64'(bus.mem_address), 64'h100);
        chk("t1_grant", 64'(bus.grant), 64'h1);
        chk("t1_busy", 64'(bus.busy), 64'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_wait_ready", 64'(bus.req0_ready), 64'h0);
            chk("t1_wait_rd_en", 64'(bus.mem_read_en), 64'h1);
        end
        finish_txn(0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
        chk("t1_idle_ready", 64'(bus.req0_ready), 64'h1);

        // Tie after req0 was served last: round-robin gives req1, fixed priority req0
`ifdef ARB_FIXED_PRIORITY_EN
        first_win = 0;
`else
        first_win = 1;
`endif
        bus.req0_read_en = 1'b1; bus.req0_address = 32'h0000_0700;
        bus.req1_read_en = 1'b1; bus.req1_address = 32'h0000_0710;
        step();
        chk("t2_grant_first", 64'(bus.grant), first_win == 1 ? 64'h2 : 64'h1);
        chk("t2_addr_first", 64'(bus.mem_address), first_win == 1 ? 64'h710 : 64'h700);
        chk("t2_loser_ready", 64'(first_win == 1 ? bus.req0_ready : bus.req1_ready), 64'h0);
        finish_txn(first_win, 64'h0000_0000_0000_0A01, 64'h0000_0000_0000_0A01);
        step();
        chk("t2_grant_second", 64'(bus.grant), first_win == 1 ? 64'h1 : 64'h2);
        chk("t2_addr_second", 64'(bus.mem_address), first_win == 1 ? 64'h700 : 64'h710);
        finish_txn(1 - first_win, 64'h0000_0000_0000_0A02, 64'h0000_0000_0000_0A02);

        // Reset, then simultaneous req0 write / req1 read: req0 first in both modes
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req0_write_en = 1'b1; bus.req0_address = 32'h0000_0200;
        bus.req0_write_data = 32'h1111_1111;
        bus.req1_read_en = 1'b1;  bus.req1_address = 32'h0000_0300;
        #1;
        chk("t3_rst_rdata0", bus.req0_read_data, 64'h0);
        chk("t3_pend_ready1", 64'(bus.req1_ready), 64'h0);
        step();
        chk("t3_grant0", 64'(bus.grant), 64'h1);
        chk("t3_wr_en", 64'(bus.mem_write_en), 64'h1);
        chk("t3_rd_en", 64'(bus.mem_read_en), 64'h0);
        chk("t3_addr", 64'(bus.mem_address), 64'h200);
        chk("t3_wdata", 64'(bus.mem_write_data), 64'h1111_1111);
        chk("t3_lose_ready1", 64'(bus.req1_ready), 64'h0);
        step();
        chk("t3_lose_ready1_b", 64'(bus.req1_ready), 64'h0);
        finish_txn(0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0);
        chk("t3_gap_wr_en", 64'(bus.mem_write_en), 64'h0);
        chk("t3_gap_ready1", 64'(bus.req1_ready), 64'h0);
        step();
        chk("t3_grant1", 64'(bus.grant), 64'h2);
        chk("t3_rd_en1", 64'(bus.mem_read_en), 64'h1);
        chk("t3_addr1", 64'(bus.mem_address), 64'h300);
        finish_txn(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // Reset during GRANT1: drop to IDLE with no ready pulse, then serve again
        bus.req1_read_en = 1'b1; bus.req1_address = 32'h0000_0400;
        step();
        chk("t4_grant1", 64'(bus.grant), 64'h2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t4_rst_grant", 64'(bus.grant), 64'h0);
        chk("t4_rst_busy", 64'(bus.busy), 64'h0);
        chk("t4_rst_rd_en", 64'(bus.mem_read_en), 64'h0);
        chk("t4_rst_ready1", 64'(bus.req1_ready), 64'h0);
        step();
        chk("t4_regrant", 64'(bus.grant), 64'h2);
        chk("t4_addr", 64'(bus.mem_address), 64'h400);
        finish_txn(1, 64'h0000_0000_0000_5555, 64'h0000_0000_0000_5555);

        // Requester withdraws and changes address mid-grant
        bus.req0_read_en = 1'b1; bus.req0_address = 32'h0000_0500;
        step();
        chk("t5_grant0", 64'(bus.grant), 64'h1);
        step();
        step();
        bus.req0_read_en = 1'b0; bus.req0_address = 32'h0000_0999;
        #1;
        chk("t5_addr_kept", 64'(bus.mem_address), 64'h500);
        chk("t5_rd_en_kept", 64'(bus.mem_read_en), 64'h1);
        chk("t5_no_ready", 64'(bus.req0_ready), 64'h0);
        step();
        chk("t5_addr_kept_b", 64'(bus.mem_address), 64'h500);
        finish_txn(0, 64'h0000_0000_0000_0077, 64'h0000_0000_0000_0077);

        // Read and write asserted together: read wins
        bus.req1_read_en = 1'b1; bus.req1_write_en = 1'b1;
        bus.req1_address = 32'h0000_0600; bus.req1_write_data = 32'h0000_0022;
        step();
        chk("t6_rd_en", 64'(bus.mem_read_en), 64'h1);
        chk("t6_wr_en", 64'(bus.mem_write_en), 64'h0);
        chk("t6_grant", 64'(bus.grant), 64'h2);
        finish_txn(1, 64'h0000_0000_0000_0066, 64'h0000_0000_0000_0066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
